bip_debug_unit: RTL and testbench

Sequencer between the UART byte interface and the BIP1 core: loads program memory, resets, runs and single-steps the CPU, and reports PC, accumulator and cycle count back over UART. Sits at top level beside `control`/datapath; sole owner of CPU enable, CPU reset and program-memory write port.

---
 rtl/bip_debug_unit_pkg.sv | 40 ++++
 rtl/bip_debug_unit_if.sv | 21 ++
 rtl/bip_cycle_counter.sv | 20 ++
 rtl/bip_debug_unit.sv | 160 ++++++++++++++++
 tb/tb_bip_debug_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_debug_unit_pkg.sv
// Shared definitions for the BIP1 debug sequencer: command opcodes, FSM states, dump layout.
package bip_debug_unit_pkg;

  localparam int NB_INSTRUC = 16;
  localparam int NB_ADDR    = 11;
  localparam int NB_DATA    = 16;
  localparam int NB_BYTE    = 8;
  localparam int NB_CYCLE   = 16;
  localparam int DUMP_LEN   = 6;
  localparam int DUMP_BITS  = DUMP_LEN * NB_BYTE;

  typedef enum logic [NB_BYTE-1:0] {
    CMD_LOAD  = 8'h4C,
    CMD_RUN   = 8'h52,
    CMD_STEP  = 8'h53,
    CMD_RESET = 8'h58
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_CNT,
    ST_LD_HI,
    ST_LD_LO,
    ST_WRITE,
    ST_CPU_RST,
    ST_RUN,
    ST_STEP,
    ST_DUMP_SEND,
    ST_DUMP_WAIT
  } state_e;

  // Byte idx of the dump word, counted from the most significant byte.
  function automatic logic [NB_BYTE-1:0] dump_byte(input logic [DUMP_BITS-1:0] word,
                                                   input logic [2:0] idx);
    logic [DUMP_BITS-1:0] shifted;
    shifted = word << (NB_BYTE * int'(idx));
    return shifted[DUMP_BITS-1 -: NB_BYTE];
  endfunction

endpackage

// File: rtl/bip_debug_unit_if.sv
// UART byte link between the UART core (master) and the debug sequencer (slave).
interface bip_debug_unit_if;
  import bip_debug_unit_pkg::*;

  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;

  modport master (
    output rx_data, rx_valid, tx_done,
    input  tx_data, tx_start
  );

  modport slave (
    input  rx_data, rx_valid, tx_done,
    output tx_data, tx_start
  );

endinterface

// File: rtl/bip_cycle_counter.sv
// Counts CPU-enabled cycles; sticks at all-ones instead of wrapping.
module bip_cycle_counter
  import bip_debug_unit_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_en,
  output logic [NB_CYCLE-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      o_count <= '0;
    end else if (i_en && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/bip_debug_unit.sv
// Debug sequencer: UART commands load program memory, reset/run/step the CPU and dump PC/ACC/cycles.
module bip_debug_unit
  import bip_debug_unit_pkg::*;
#(
  parameter int NB_INSTRUC = bip_debug_unit_pkg::NB_INSTRUC,
  parameter int NB_ADDR    = bip_debug_unit_pkg::NB_ADDR,
  parameter int NB_DATA    = bip_debug_unit_pkg::NB_DATA
)
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  bip_debug_unit_if.slave       uart,
  output logic                  o_prog_we,
  output logic [NB_ADDR-1:0]    o_prog_addr,
  output logic [NB_INSTRUC-1:0] o_prog_data,
  output logic                  o_cpu_en,
  output logic                  o_cpu_rst,
  input  logic [NB_ADDR-1:0]    i_pc,
  input  logic [NB_DATA-1:0]    i_acc,
  input  logic                  i_halt,
  output logic                  o_busy
);

  state_e               state;
  logic [8:0]           load_left;
  logic [NB_ADDR-1:0]   load_addr;
  logic [NB_BYTE-1:0]   hi_byte;
  logic [2:0]           byte_idx;
  logic [DUMP_BITS-1:0] snapshot;
  logic [DUMP_BITS-1:0] live_word;
  logic [DUMP_BITS-1:0] dump_word;
  logic [NB_CYCLE-1:0]  cycle_count;

  // Enable must drop in the very cycle halt rises, so it is decoded rather than registered.
  assign o_cpu_en = ((state == ST_RUN) || (state == ST_STEP)) && !i_halt;
  assign o_busy   = (state != ST_IDLE);

  bip_cycle_counter u_cycle_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state == ST_CPU_RST),
    .i_en    (o_cpu_en),
    .o_count (cycle_count)
  );

  // Snapshot is latched while the first byte goes out, after the last enabled edge has settled.
  assign live_word = {16'(i_pc), 16'(i_acc), cycle_count};
  assign dump_word = (byte_idx == 3'd0) ? live_word : snapshot;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      load_left     <= '0;
      load_addr     <= '0;
      hi_byte       <= '0;
      byte_idx      <= '0;
      snapshot      <= '0;
      o_prog_we     <= 1'b0;
      o_prog_addr   <= '0;
      o_prog_data   <= '0;
      o_cpu_rst     <= 1'b0;
      uart.tx_data  <= '0;
      uart.tx_start <= 1'b0;
    end else begin
      o_prog_we     <= 1'b0;
      o_cpu_rst     <= 1'b0;
      uart.tx_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (uart.rx_valid) begin
            case (uart.rx_data)
              CMD_LOAD:  state <= ST_LD_CNT;
              CMD_RUN:   state <= ST_RUN;
              CMD_STEP:  state <= ST_STEP;
              CMD_RESET: begin
                state     <= ST_CPU_RST;
                o_cpu_rst <= 1'b1;
              end
              default:   state <= ST_IDLE;
            endcase
          end
        end

        ST_LD_CNT: begin
          if (uart.rx_valid) begin
            load_left <= (uart.rx_data == '0) ? 9'd256 : {1'b0, uart.rx_data};
            load_addr <= '0;
            state     <= ST_LD_HI;
          end
        end

        ST_LD_HI: begin
          if (uart.rx_valid) begin
            hi_byte <= uart.rx_data;
            state   <= ST_LD_LO;
          end
        end

        ST_LD_LO: begin
          if (uart.rx_valid) begin
            o_prog_we   <= 1'b1;
            o_prog_addr <= load_addr;
            o_prog_data <= NB_INSTRUC'({hi_byte, uart.rx_data});
            state       <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          load_addr <= load_addr + 1'b1;
          load_left <= load_left - 9'd1;
          if (load_left == 9'd1) begin
            state     <= ST_CPU_RST;
            o_cpu_rst <= 1'b1;
          end else begin
            state <= ST_LD_HI;
          end
        end

        ST_CPU_RST: state <= ST_IDLE;

        ST_RUN: begin
          if (i_halt) begin
            byte_idx <= '0;
            state    <= ST_DUMP_SEND;
          end
        end

        ST_STEP: begin
          byte_idx <= '0;
          state    <= ST_DUMP_SEND;
        end

        ST_DUMP_SEND: begin
          if (byte_idx == 3'd0) begin
            snapshot <= live_word;
          end
          uart.tx_data  <= dump_byte(dump_word, byte_idx);
          uart.tx_start <= 1'b1;
          state         <= ST_DUMP_WAIT;
        end

        ST_DUMP_WAIT: begin
          if (uart.tx_done) begin
            if (byte_idx == 3'(DUMP_LEN - 1)) begin
              byte_idx <= '0;
              state    <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= ST_DUMP_SEND;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_debug_unit.sv
// Scoreboard bench for bip_debug_unit: a stub CPU and UART responder around the DUT, expectations from a high-level model.
module tb_bip_debug_unit;
  import bip_debug_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we;
  logic [10:0] prog_addr;
  logic [15:0] prog_data;
  logic        cpu_en;
  logic        cpu_rst;
  logic [10:0] cpu_pc;
  logic [15:0] cpu_acc;
  logic        cpu_halt;
  logic        busy;

  always #5 clk = ~clk;

  bip_debug_unit_if uart();

  bip_debug_unit dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .uart        (uart.slave),
    .o_prog_we   (prog_we),
    .o_prog_addr (prog_addr),
    .o_prog_data (prog_data),
    .o_cpu_en    (cpu_en),
    .o_cpu_rst   (cpu_rst),
    .i_pc        (cpu_pc),
    .i_acc       (cpu_acc),
    .i_halt      (cpu_halt),
    .o_busy      (busy)
  );

  // Stub CPU: PC advances on enable, halts once its enable budget is spent.
  logic [10:0] stub_pc;
  int unsigned stub_en_count = 0;
  int unsigned halt_at_count = 0;
  logic [15:0] acc_val = 16'h0;

  always @(posedge clk) begin
    if (rst || cpu_rst) stub_pc <= '0;
    else if (cpu_en)    stub_pc <= stub_pc + 11'd1;
    if (cpu_en) stub_en_count <= stub_en_count + 1;
  end

  assign cpu_pc   = stub_pc;
  assign cpu_acc  = acc_val;
  assign cpu_halt = (stub_en_count >= halt_at_count);

  int total = 0;
  int bad   = 0;
  int rst_epoch = 0;

  logic [26:0] exp_wr_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [15:0] prog_words[256];

  int unsigned m_pc = 0;
  int unsigned m_count = 0;
  int          exp_crst = 0;

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a transmit byte.
  logic prev_we = 1'b0, prev_tx = 1'b0, prev_crst = 1'b0;
  int   en_seen = 0, crst_seen = 0;

  always @(negedge clk) begin
    if (prog_we) begin
      checkOutput("prog_we_width", 48'(prev_we), 48'd0);
      if (exp_wr_q.size() == 0) checkOutput("prog_write_unexpected", 48'd1, 48'd0);
      else checkOutput("prog_write", 48'({prog_addr, prog_data}), 48'(exp_wr_q.pop_front()));
    end
    if (uart.tx_start) begin
      checkOutput("tx_start_width", 48'(prev_tx), 48'd0);
      if (exp_tx_q.size() == 0) checkOutput("tx_unexpected", 48'd1, 48'd0);
      else checkOutput("tx_byte", 48'(uart.tx_data), 48'(exp_tx_q.pop_front()));
    end
    if (cpu_rst) begin
      checkOutput("cpu_rst_width", 48'(prev_crst), 48'd0);
      crst_seen <= crst_seen + 1;
    end
    if (cpu_en) en_seen <= en_seen + 1;
    prev_we   <= prog_we;
    prev_tx   <= uart.tx_start;
    prev_crst <= cpu_rst;
  end

  // UART transmitter model: acknowledges each started byte after a short random delay.
  int          resp_epoch;
  int          resp_delay;
  logic [7:0]  resp_held;

  initial begin
    uart.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (uart.tx_start) begin
        resp_epoch = rst_epoch;
        resp_held  = uart.tx_data;
        resp_delay = $urandom_range(2, 5);
        repeat (resp_delay) @(negedge clk);
        if (resp_epoch == rst_epoch) begin
          checkOutput("tx_data_hold", 48'(uart.tx_data), 48'(resp_held));
          uart.tx_done = 1'b1;
          @(negedge clk);
          uart.tx_done = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    uart.rx_data  = b;
    uart.rx_valid = 1'b1;
    @(negedge clk);
    uart.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 48'(busy), 48'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checkOutput({tag, "_tx_data"},   48'(uart.tx_data),  48'd0);
    checkOutput({tag, "_tx_start"},  48'(uart.tx_start), 48'd0);
    checkOutput({tag, "_prog_we"},   48'(prog_we),       48'd0);
    checkOutput({tag, "_prog_addr"}, 48'(prog_addr),     48'd0);
    checkOutput({tag, "_prog_data"}, 48'(prog_data),     48'd0);
    checkOutput({tag, "_cpu_en"},    48'(cpu_en),        48'd0);
    checkOutput({tag, "_cpu_rst"},   48'(cpu_rst),       48'd0);
    checkOutput({tag, "_busy"},      48'(busy),          48'd0);
  endtask

  task automatic mid_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs(tag);
    rst = 1'b0;
    rst_epoch++;
    exp_wr_q.delete();
    exp_tx_q.delete();
    m_pc = 0;
    m_count = 0;
  endtask

  // Model of a run/step: enabled cycles follow from the halt budget, then a 6-byte dump.
  task automatic prepare_cpu_cmd(input logic [7:0] cmd, input int unsigned steps,
                                 input logic [15:0] acc, output int unsigned enabled);
    logic [47:0] dump;
    acc_val = acc;
    halt_at_count = stub_en_count + steps;
    enabled = (cmd == CMD_RUN) ? steps : ((steps > 0) ? 1 : 0);
    m_pc = (m_pc + enabled) % 2048;
    m_count = (m_count + enabled > 65535) ? 65535 : m_count + enabled;
    dump = {16'(m_pc), acc, 16'(m_count)};
    for (int i = 0; i < 6; i++) exp_tx_q.push_back(dump[47 - 8*i -: 8]);
  endtask

  task automatic do_cpu_cmd(input logic [7:0] cmd, input int unsigned steps,
                            input logic [15:0] acc, input int bound);
    int unsigned enabled;
    int en_before;
    prepare_cpu_cmd(cmd, steps, acc, enabled);
    en_before = en_seen;
    applyStimulus(cmd);
    wait_idle(bound);
    checkOutput("en_cycles", 48'(en_seen - en_before), 48'(enabled));
  endtask

  task automatic do_reset_cmd();
    exp_crst++;
    m_pc = 0;
    m_count = 0;
    applyStimulus(CMD_RESET);
    wait_idle(20);
    checkOutput("cpu_rst_count", 48'(crst_seen), 48'(exp_crst));
  endtask

  task automatic do_load(input int n);
    applyStimulus(CMD_LOAD);
    applyStimulus(8'(n));
    for (int i = 0; i < ((n == 0) ? 256 : n); i++) begin
      applyStimulus(prog_words[i][15:8]);
      exp_wr_q.push_back({11'(i), prog_words[i]});
      applyStimulus(prog_words[i][7:0]);
    end
    exp_crst++;
    m_pc = 0;
    m_count = 0;
    wait_idle(20);
    checkOutput("load_cpu_rst_count", 48'(crst_seen), 48'(exp_crst));
    checkOutput("load_writes_left", 48'(exp_wr_q.size()), 48'd0);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned enabled;
    int          waited;
    logic [7:0]  junk;
    uart.rx_valid = 1'b0;
    uart.rx_data  = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed two-word load");
    prog_words[0] = 16'h0805;
    prog_words[1] = 16'h1003;
    do_load(2);

    $display("[TB] directed run to halt after 7 cycles");
    do_reset_cmd();
    do_cpu_cmd(CMD_RUN, 7, 16'h0012, 200);

    $display("[TB] directed steps and halted cases");
    do_reset_cmd();
    do_cpu_cmd(CMD_STEP, 5, 16'h1234, 100);
    do_cpu_cmd(CMD_STEP, 4, 16'h5678, 100);
    do_cpu_cmd(CMD_STEP, 0, 16'h9ABC, 100);
    do_cpu_cmd(CMD_RUN,  0, 16'hDEF0, 100);

    $display("[TB] load of 256 words");
    for (int i = 0; i < 256; i++) prog_words[i] = 16'($urandom);
    do_load(0);

    $display("[TB] reset during load and during dump");
    applyStimulus(CMD_LOAD);
    applyStimulus(8'd3);
    prog_words[0] = 16'hA55A;
    applyStimulus(prog_words[0][15:8]);
    exp_wr_q.push_back({11'd0, prog_words[0]});
    applyStimulus(prog_words[0][7:0]);
    applyStimulus(8'h77);
    mid_reset("rst_ld_lo");
    do_reset_cmd();

    prepare_cpu_cmd(CMD_STEP, 3, 16'h4321, enabled);
    applyStimulus(CMD_STEP);
    waited = 0;
    while (!uart.tx_start && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("dump_start_seen", 48'(uart.tx_start), 48'd1);
    mid_reset("rst_dump_wait");
    do_reset_cmd();

    $display("[TB] randomized commands");
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          junk = 8'($urandom);
          while (junk == CMD_LOAD || junk == CMD_RUN || junk == CMD_STEP || junk == CMD_RESET)
            junk = 8'($urandom);
          applyStimulus(junk);
          checkOutput("junk_stays_idle", 48'(busy), 48'd0);
        end
        1: do_reset_cmd();
        2: do_cpu_cmd(CMD_STEP, $urandom_range(0, 2), 16'($urandom), 100);
        3: do_cpu_cmd(CMD_RUN, $urandom_range(0, 30), 16'($urandom), 200);
        default: begin
          for (int i = 0; i < 4; i++) prog_words[i] = 16'($urandom);
          do_load($urandom_range(1, 4));
        end
      endcase
    end

    $display("[TB] cycle counter saturation");
    do_reset_cmd();
    do_cpu_cmd(CMD_RUN, 65600, 16'h0BAD, 70000);
    do_cpu_cmd(CMD_STEP, 3, 16'h0ACE, 100);

    repeat (5) @(negedge clk);
    checkOutput("final_writes_left", 48'(exp_wr_q.size()), 48'd0);
    checkOutput("final_tx_left", 48'(exp_tx_q.size()), 48'd0);
    checkOutput("final_cpu_rst_count", 48'(crst_seen), 48'(exp_crst));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
